uart_core: RTL and testbench

Single-channel UART peripheral on the register side of the shared-UART arbiter: it receives the arbiter's rd/wr/addr/din strobes and returns status and receive data. Serialises one 8N1 transmit byte at a time from a one-byte holding register and deserialises received 8N1 frames into a one-byte receive register with overrun and framing flags. Sits between the arbiter and the board TXD/RXD pins.

---
 rtl/uart_core_pkg.sv | 31 +++
 rtl/uart_rx.sv | 108 ++++++++++
 rtl/uart_core.sv | 177 +++++++++++++++++
 tb/tb_uart_core.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_core_pkg.sv
// Shared constants for the UART peripheral: register map, STATUS bit positions
// and the TX/RX state encodings.
package uart_core_pkg;

   localparam int UART_DATA_W = 8;

   localparam logic [1:0] UART_ADDR_DATA   = 2'b00;
   localparam logic [1:0] UART_ADDR_STATUS = 2'b01;

   localparam int ST_TX_READY  = 0;
   localparam int ST_RX_VALID  = 1;
   localparam int ST_OVERRUN   = 2;
   localparam int ST_FRAME_ERR = 3;
   localparam int ST_TX_BUSY   = 4;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE    = 3'd0,
      RX_START   = 3'd1,
      RX_DATA    = 3'd2,
      RX_STOP    = 3'd3,
      RX_WAIT_HI = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronises rxd, samples at bit centres and reports each frame
// with a one-cycle done (good stop bit) or ferr (bad stop bit) pulse.
module uart_rx
   import uart_core_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_W       = UART_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_rxd,
   output logic [DATA_W-1:0] o_rx_byte,
   output logic              o_rx_done,
   output logic              o_rx_ferr
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   logic              r_sync0;
   logic              r_sync1;
   logic              r_sync2;
   rx_state_t         r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [BIT_W-1:0]  r_bit;
   logic [DATA_W-1:0] r_shift;

   logic w_fall;
   logic w_bit_end;

   assign w_fall    = r_sync2 & ~r_sync1;
   assign w_bit_end = (r_cnt == CNT_LAST);

   // Pulses are decoded from the stop-bit sample so the core registers them one cycle later.
   assign o_rx_done = (r_state == RX_STOP) && w_bit_end && r_sync1;
   assign o_rx_ferr = (r_state == RX_STOP) && w_bit_end && !r_sync1;
   assign o_rx_byte = r_shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync0 <= 1'b1;
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync0 <= i_rxd;
         r_sync1 <= r_sync0;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RX_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
      end else begin
         case (r_state)
            RX_IDLE: begin
               r_cnt <= '0;
               r_bit <= '0;
               if (w_fall) r_state <= RX_START;
            end
            RX_START: begin
               if (r_cnt == CNT_HALF) begin
                  r_cnt   <= '0;
                  r_state <= r_sync1 ? RX_IDLE : RX_DATA;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_bit == BIT_LAST) begin
                     r_bit   <= '0;
                     r_state <= RX_STOP;
                  end else begin
                     r_bit <= r_bit + BIT_W'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_state <= r_sync1 ? RX_IDLE : RX_WAIT_HI;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            RX_WAIT_HI: begin
               r_cnt <= '0;
               if (r_sync1) r_state <= RX_IDLE;
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == RX_DATA && w_bit_end) r_shift <= {r_sync1, r_shift[DATA_W-1:1]};
   end

endmodule

// File: rtl/uart_core.sv
// Single-channel UART register block: one-byte TX holding register feeding an
// 8N1 shifter, plus RX data register with rx_valid/overrun/frame_err flags.
module uart_core
   import uart_core_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_W       = UART_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd,
   input  logic              wr,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [DATA_W-1:0] dout1,
   input  logic              rxd,
   output logic              txd
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   tx_state_t         r_tx_state;
   logic [CNT_W-1:0]  r_tx_cnt;
   logic [BIT_W-1:0]  r_tx_bit;
   logic [DATA_W-1:0] r_tx_shift;
   logic              r_txd;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_full;
   logic [DATA_W-1:0] r_rx_data;
   logic              r_rx_valid;
   logic              r_overrun;
   logic              r_ferr;

   logic              w_wr_data;
   logic              w_wr_status;
   logic              w_rd_data;
   logic              w_hold_accept;
   logic              w_tx_bit_end;
   logic              w_tx_take;
   logic [DATA_W-1:0] w_rx_byte;
   logic              w_rx_done;
   logic              w_rx_ferr;
   logic [DATA_W-1:0] w_status;

   assign w_wr_data     = wr && (addr == UART_ADDR_DATA);
   assign w_wr_status   = wr && (addr == UART_ADDR_STATUS);
   assign w_rd_data     = rd && (addr == UART_ADDR_DATA);
   assign w_hold_accept = w_wr_data && !r_hold_full;
   assign w_tx_bit_end  = (r_tx_cnt == CNT_LAST);
   // The shifter takes the holding byte when idle or at the end of a stop bit (back-to-back).
   assign w_tx_take     = r_hold_full &&
                          ((r_tx_state == TX_IDLE) || (r_tx_state == TX_STOP && w_tx_bit_end));

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .DATA_W      (DATA_W)
   ) u_rx (
      .clk      (clk),
      .rst      (rst),
      .i_rxd    (rxd),
      .o_rx_byte(w_rx_byte),
      .o_rx_done(w_rx_done),
      .o_rx_ferr(w_rx_ferr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state  <= TX_IDLE;
         r_tx_cnt    <= '0;
         r_tx_bit    <= '0;
         r_txd       <= 1'b1;
         r_hold_full <= 1'b0;
      end else begin
         if (w_tx_take)          r_hold_full <= 1'b0;
         else if (w_hold_accept) r_hold_full <= 1'b1;
         case (r_tx_state)
            TX_IDLE: begin
               r_tx_cnt <= '0;
               r_tx_bit <= '0;
               r_txd    <= 1'b1;
               if (r_hold_full) begin
                  r_tx_state <= TX_START;
                  r_txd      <= 1'b0;
               end
            end
            TX_START: begin
               if (w_tx_bit_end) begin
                  r_tx_cnt   <= '0;
                  r_tx_state <= TX_DATA;
                  r_txd      <= r_tx_shift[0];
               end else begin
                  r_tx_cnt <= r_tx_cnt + CNT_W'(1);
               end
            end
            TX_DATA: begin
               if (w_tx_bit_end) begin
                  r_tx_cnt <= '0;
                  if (r_tx_bit == BIT_LAST) begin
                     r_tx_bit   <= '0;
                     r_tx_state <= TX_STOP;
                     r_txd      <= 1'b1;
                  end else begin
                     r_tx_bit <= r_tx_bit + BIT_W'(1);
                     r_txd    <= r_tx_shift[1];
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + CNT_W'(1);
               end
            end
            TX_STOP: begin
               if (w_tx_bit_end) begin
                  r_tx_cnt <= '0;
                  if (r_hold_full) begin
                     r_tx_state <= TX_START;
                     r_txd      <= 1'b0;
                  end else begin
                     r_tx_state <= TX_IDLE;
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + CNT_W'(1);
               end
            end
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_hold_accept) r_hold <= din;
   end

   always_ff @(posedge clk) begin
      if (w_tx_take)                                   r_tx_shift <= r_hold;
      else if (r_tx_state == TX_DATA && w_tx_bit_end) r_tx_shift <= r_tx_shift >> 1;
   end

   // Status writes clear first so a flag raised in the same cycle still sticks.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_overrun  <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         if (w_rd_data) r_rx_valid <= 1'b0;
         if (w_wr_status && din[ST_OVERRUN])   r_overrun <= 1'b0;
         if (w_wr_status && din[ST_FRAME_ERR]) r_ferr    <= 1'b0;
         if (w_rx_done) begin
            if (!r_rx_valid || w_rd_data) begin
               r_rx_data  <= w_rx_byte;
               r_rx_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end
         if (w_rx_ferr) r_ferr <= 1'b1;
      end
   end

   always_comb begin
      w_status               = '0;
      w_status[ST_TX_READY]  = ~r_hold_full;
      w_status[ST_RX_VALID]  = r_rx_valid;
      w_status[ST_OVERRUN]   = r_overrun;
      w_status[ST_FRAME_ERR] = r_ferr;
      w_status[ST_TX_BUSY]   = (r_tx_state != TX_IDLE);
   end

   assign dout  = w_status;
   assign dout1 = r_rx_data;
   assign txd   = r_txd;

endmodule

// File: tb/tb_uart_core.sv
// Directed and randomized bench for uart_core at 16 clocks per bit, checked
// against a frame-level model of the serial line and register flags.
`timescale 1ns/1ps
module tb_uart_core;

   localparam int CPB   = 16;
   localparam int FRAME = 10 * CPB;
   localparam int NREC  = 3 * FRAME + CPB;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       rd   = 1'b0;
   logic       wr   = 1'b0;
   logic [1:0] addr = 2'b00;
   logic [7:0] din  = 8'h00;
   logic [7:0] dout;
   logic [7:0] dout1;
   logic       rxd  = 1'b1;
   logic       txd;

   int n_tests = 0;
   int n_fail  = 0;

   // Register model
   logic       mv = 1'b0;
   logic       mo = 1'b0;
   logic       mf = 1'b0;
   logic [7:0] md = 8'h00;

   logic       txs [0:NREC-1];
   logic [7:0] exp_tx [$];

   uart_core #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .rd   (rd),
      .wr   (wr),
      .addr (addr),
      .din  (din),
      .dout (dout),
      .dout1(dout1),
      .rxd  (rxd),
      .txd  (txd)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write(input logic [1:0] a, input logic [7:0] d);
      addr = a; din = d; wr = 1'b1;
      tick();
      wr = 1'b0;
   endtask

   task automatic read(input logic [1:0] a);
      addr = a; rd = 1'b1;
      tick();
      rd = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_status"}, dout, {4'b0000, mf, mo, mv, 1'b1});
      check({tag, "_data"}, dout1, md);
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stop);
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         tick(CPB);
      end
      rxd = stop;
      tick(CPB);
      rxd = 1'b1;
      tick(4);
   endtask

   task automatic model_frame(input logic [7:0] d, input logic stop);
      if (!stop)    mf = 1'b1;
      else if (!mv) begin md = d; mv = 1'b1; end
      else          mo = 1'b1;
   endtask

   task automatic record_tx(input int nsamp);
      int w = 0;
      while (txd !== 1'b0 && w < 400) begin
         tick();
         w++;
      end
      check("tx_start_seen", txd, 1'b0);
      for (int i = 0; i < nsamp; i++) begin
         txs[i] = txd;
         tick();
      end
   endtask

   // Each bit period must hold a constant level equal to the 8N1 frame bit.
   task automatic check_tx(input string tag);
      int nf = exp_tx.size();
      for (int f = 0; f < nf; f++) begin
         for (int b = 0; b < 10; b++) begin
            logic eb;
            logic ob;
            int base = f * FRAME + b * CPB;
            eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_tx[f][b-1];
            ob = txs[base];
            for (int k = 1; k < CPB; k++) if (txs[base+k] !== ob) ob = 1'bx;
            check($sformatf("%s_f%0d_b%0d", tag, f, b), ob, eb);
         end
      end
      begin
         logic ob = 1'b1;
         for (int k = 0; k < CPB; k++) if (txs[nf*FRAME+k] !== 1'b1) ob = 1'b0;
         check({tag, "_idle_after"}, ob, 1'b1);
      end
   endtask

   task automatic poll_ready(input string tag);
      int w = 0;
      while (dout[0] !== 1'b1 && w < 2 * FRAME) begin
         tick();
         w++;
      end
      check(tag, dout[0], 1'b1);
   endtask

   initial begin
      int bad;
      logic [7:0] d;

      tick(3);
      rst = 1'b0;
      check("rst_dout", dout, 8'h01);
      check("rst_dout1", dout1, 8'h00);
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (txd !== 1'b1) bad++;
         tick();
      end
      check("rst_txd_idle_cycles_bad", bad, 0);

      // Single frame 8'hA5
      write(2'b00, 8'hA5);
      check("a5_txd_before", txd, 1'b1);
      check("a5_hold_full", dout[0], 1'b0);
      tick();
      check("a5_txd_low_n2", txd, 1'b0);
      check("a5_ready_n2", dout[0], 1'b1);
      check("a5_busy", dout[4], 1'b1);
      record_tx(FRAME + CPB);
      exp_tx = '{8'hA5};
      check_tx("a5");
      check("a5_done_status", dout, 8'h01);

      // Back-to-back frames with one dropped write
      fork
         begin
            write(2'b00, 8'h11);
            poll_ready("b2b_ready1");
            write(2'b00, 8'h22);
            check("b2b_hold_full", dout[0], 1'b0);
            write(2'b00, 8'h99);
            poll_ready("b2b_ready2");
            write(2'b00, 8'h33);
         end
         record_tx(NREC);
      join
      exp_tx = '{8'h11, 8'h22, 8'h33};
      check_tx("b2b");
      check("b2b_done_status", dout, 8'h01);

      // Reserved address and STATUS read have no effect
      write(2'b10, 8'hFF);
      read(2'b01);
      read(2'b11);
      check_regs("reserved");

      // RX frame 8'h3C then read
      send_rx(8'h3C, 1'b1);
      model_frame(8'h3C, 1'b1);
      check_regs("rx3c");
      read(2'b00);
      mv = 1'b0;
      check("rx3c_read_dout", dout, 8'h01);
      check("rx3c_read_dout1", dout1, 8'h3C);

      // Overrun
      send_rx(8'h01, 1'b1);
      model_frame(8'h01, 1'b1);
      send_rx(8'h02, 1'b1);
      model_frame(8'h02, 1'b1);
      check_regs("ovr");
      write(2'b01, 8'h04);
      mo = 1'b0;
      check_regs("ovr_clear");

      // Framing error
      read(2'b00);
      mv = 1'b0;
      send_rx(8'h55, 1'b0);
      model_frame(8'h55, 1'b0);
      check_regs("ferr");
      write(2'b01, 8'h08);
      mf = 1'b0;
      check_regs("ferr_clear");

      // 8-cycle glitch is a false start
      rxd = 1'b0;
      tick(8);
      rxd = 1'b1;
      tick(3 * FRAME);
      check_regs("glitch");

      // Randomized RX frames with random reads
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom);
         send_rx(d, 1'b1);
         model_frame(d, 1'b1);
         check_regs($sformatf("rnd%0d", i));
         if ($urandom_range(0, 1) == 1) begin
            read(2'b00);
            mv = 1'b0;
            check_regs($sformatf("rnd%0d_rd", i));
         end
      end

      // Simultaneous read and write of DATA; random TX byte
      d = 8'($urandom);
      addr = 2'b00; din = d; rd = 1'b1; wr = 1'b1;
      tick();
      rd = 1'b0; wr = 1'b0;
      mv = 1'b0;
      check("rdwr_status", dout, {4'b0000, mf, mo, mv, 1'b0});
      tick();
      record_tx(FRAME + CPB);
      exp_tx = '{d};
      check_tx("rnd_tx");

      // Reset in mid TX frame
      write(2'b00, 8'h00);
      tick(40);
      check("midrst_busy", dout[4], 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mv = 1'b0; mo = 1'b0; mf = 1'b0; md = 8'h00;
      check("midrst_txd", txd, 1'b1);
      check_regs("midrst");
      bad = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (txd !== 1'b1) bad++;
         tick();
      end
      check("midrst_txd_idle_cycles_bad", bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
